// File: rtl/npc_btb_predictor.sv
// Next-PC selection for IF: direct-mapped BTB with 2-bit direction counters,
// ID/EX redirect priority, mispredict flag and branch performance counters.
module npc_btb_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc_if,
    input  logic [XLEN-1:0]  pc_if_plus4,
    input  logic             jal,
    input  logic [XLEN-1:0]  jal_target,
    input  logic             jalr,
    input  logic [XLEN-1:0]  jalr_target,
    input  logic             br_ex,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  br_target,
    input  logic [XLEN-1:0]  pc_ex,
    input  logic             pred_taken_ex,
    output logic [XLEN-1:0]  NPC,
    output logic             pred_taken_if,
    output logic             mispredict,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [XLEN-1:0]    tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];
    logic [CNT_W-1:0]   br_count_q;
    logic [CNT_W-1:0]   mispred_count_q;

    logic [IDX-1:0]   if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic [IDX-1:0]   ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic [1:0]       ex_ctr;
    logic [1:0]       ex_ctr_d;
    logic [XLEN-1:0]  pc_ex_plus4;

    // Byte-offset bits never address the BTB (instructions are word aligned).
    logic unused_offset_bits;
    assign unused_offset_bits = ^{pc_if[1:0], pc_ex[1:0]};

    assign if_idx = pc_if[IDX+1:2];
    assign if_tag = pc_if[XLEN-1:IDX+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    assign ex_idx = pc_ex[IDX+1:2];
    assign ex_tag = pc_ex[XLEN-1:IDX+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign ex_ctr = ctr_q[ex_idx];

    assign pc_ex_plus4   = pc_ex + {{(XLEN-3){1'b0}}, 3'd4};
    assign pred_taken_if = if_hit && ctr_q[if_idx][1];
    assign mispredict    = br_ex && (br_taken != pred_taken_ex);

    always_comb begin
        ex_ctr_d = ex_ctr;
        if (br_taken) begin
            if (ex_ctr != 2'b11) ex_ctr_d = ex_ctr + 2'd1;
        end else begin
            if (ex_ctr != 2'b00) ex_ctr_d = ex_ctr - 2'd1;
        end
    end

    always_comb begin
        if (jalr)                        NPC = jalr_target;
        else if (mispredict && br_taken) NPC = br_target;
        else if (mispredict)             NPC = pc_ex_plus4;
        else if (jal)                    NPC = jal_target;
        else if (pred_taken_if)          NPC = tgt_q[if_idx];
        else                             NPC = pc_if_plus4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= 2'b01;
            end
        end else if (br_ex) begin
            if (ex_hit) begin
                ctr_q[ex_idx] <= ex_ctr_d;
                tgt_q[ex_idx] <= br_target;
            end else if (br_taken) begin
                valid_q[ex_idx] <= 1'b1;
                tag_q[ex_idx]   <= ex_tag;
                tgt_q[ex_idx]   <= br_target;
                ctr_q[ex_idx]   <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            if (br_ex)      br_count_q      <= br_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (mispredict) mispred_count_q <= mispred_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_npc_btb_predictor.sv
// Scoreboard bench for npc_btb_predictor: driver pushes model expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_npc_btb_predictor;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int CNT_W   = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [XLEN-1:0]  pc_if = '0, pc_if_plus4 = '0;
    logic             jal = 1'b0, jalr = 1'b0, br_ex = 1'b0, br_taken = 1'b0, pred_taken_ex = 1'b0;
    logic [XLEN-1:0]  jal_target = '0, jalr_target = '0, br_target = '0, pc_ex = '0;
    logic [XLEN-1:0]  NPC;
    logic             pred_taken_if, mispredict;
    logic [CNT_W-1:0] br_count, mispred_count;

    npc_btb_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .pc_if(pc_if), .pc_if_plus4(pc_if_plus4),
        .jal(jal), .jal_target(jal_target), .jalr(jalr), .jalr_target(jalr_target),
        .br_ex(br_ex), .br_taken(br_taken), .br_target(br_target), .pc_ex(pc_ex),
        .pred_taken_ex(pred_taken_ex), .NPC(NPC), .pred_taken_if(pred_taken_if),
        .mispredict(mispredict), .br_count(br_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        r;
        bit [31:0] pc;
        bit        jal;
        bit [31:0] jal_t;
        bit        jalr;
        bit [31:0] jalr_t;
        bit        br;
        bit        tk;
        bit [31:0] br_t;
        bit [31:0] pcx;
        bit        pex;
    } stim_t;

    typedef struct {
        bit [31:0] npc;
        bit        pti;
        bit        misp;
        bit [31:0] brc;
        bit [31:0] mpc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   drive_done = 0;

    // Reference BTB: indexed by word address modulo ENTRIES, tag is the rest.
    bit        m_valid [ENTRIES];
    bit [31:0] m_tag   [ENTRIES];
    bit [31:0] m_tgt   [ENTRIES];
    int        m_ctr   [ENTRIES];
    bit [31:0] m_brc, m_mpc;

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_brc = 0; m_mpc = 0;
    endfunction

    function automatic int idx_of(bit [31:0] a);
        return int'((a / 4) % ENTRIES);
    endfunction

    function automatic bit [31:0] tag_of(bit [31:0] a);
        return a / (4 * ENTRIES);
    endfunction

    function automatic bit model_hit(bit [31:0] a);
        return m_valid[idx_of(a)] && m_tag[idx_of(a)] == tag_of(a);
    endfunction

    function automatic stim_t idle(bit [31:0] pc);
        stim_t s;
        s = '{default: 0};
        s.pc = pc;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        bit   pti, misp;
        int   i;
        @(posedge clk);
        #1;
        rst = s.r;
        pc_if = s.pc; pc_if_plus4 = s.pc + 32'd4;
        jal = s.jal; jal_target = s.jal_t; jalr = s.jalr; jalr_target = s.jalr_t;
        br_ex = s.br; br_taken = s.tk; br_target = s.br_t; pc_ex = s.pcx; pred_taken_ex = s.pex;
        if (s.r) model_reset();
        pti  = model_hit(s.pc) && (m_ctr[idx_of(s.pc)] >= 2);
        misp = s.br && (s.tk != s.pex);
        if (s.jalr)          e.npc = s.jalr_t;
        else if (misp && s.tk) e.npc = s.br_t;
        else if (misp)       e.npc = s.pcx + 32'd4;
        else if (s.jal)      e.npc = s.jal_t;
        else if (pti)        e.npc = m_tgt[idx_of(s.pc)];
        else                 e.npc = s.pc + 32'd4;
        e.pti = pti; e.misp = misp; e.brc = m_brc; e.mpc = m_mpc;
        exp_q.push_back(e);
        if (!s.r && s.br) begin
            i = idx_of(s.pcx);
            if (model_hit(s.pcx)) begin
                m_ctr[i] = s.tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                m_tgt[i] = s.br_t;
            end else if (s.tk) begin
                m_valid[i] = 1; m_tag[i] = tag_of(s.pcx); m_tgt[i] = s.br_t; m_ctr[i] = 2;
            end
            m_brc++;
            if (misp) m_mpc++;
        end
    endtask

    task automatic branch(input bit [31:0] pc, input bit [31:0] pcx, input bit tk,
                          input bit pex, input bit [31:0] tgt);
        stim_t s;
        s = idle(pc);
        s.br = 1; s.pcx = pcx; s.tk = tk; s.pex = pex; s.br_t = tgt;
        apply(s);
    endtask

    function automatic bit [31:0] pick_pc();
        bit [31:0] pool [8];
        pool = '{32'h200, 32'h240, 32'h204, 32'h280, 32'h100, 32'hFFFF_FFFC, 32'h23C, 32'h1200};
        return pool[$urandom_range(7)];
    endfunction

    // Monitor: one expectation per driven cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total += 5;
                if (NPC !== e.npc) begin
                    bad++; $display("FAIL npc: got %h expected %h (t=%0t)", NPC, e.npc, $time);
                end
                if (pred_taken_if !== e.pti) begin
                    bad++; $display("FAIL pred_taken_if: got %b expected %b (t=%0t)", pred_taken_if, e.pti, $time);
                end
                if (mispredict !== e.misp) begin
                    bad++; $display("FAIL mispredict: got %b expected %b (t=%0t)", mispredict, e.misp, $time);
                end
                if (br_count !== e.brc) begin
                    bad++; $display("FAIL br_count: got %0d expected %0d (t=%0t)", br_count, e.brc, $time);
                end
                if (mispred_count !== e.mpc) begin
                    bad++; $display("FAIL mispred_count: got %0d expected %0d (t=%0t)", mispred_count, e.mpc, $time);
                end
            end else if (drive_done) begin
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL timeout: simulation did not complete, queue=%0d", exp_q.size());
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        stim_t s;
        model_reset();
        s = idle(32'h100); s.r = 1;
        apply(s);
        apply(idle(32'h100));
        // Allocate at 0x200 and then look it up.
        branch(32'h100, 32'h200, 1, 0, 32'h180);
        apply(idle(32'h200));
        // Counter walk: 10 -> 11 -> 11 -> 10 -> 01.
        branch(32'h200, 32'h200, 1, 1, 32'h180);
        branch(32'h200, 32'h200, 1, 1, 32'h180);
        branch(32'h200, 32'h200, 0, 1, 32'h180);
        apply(idle(32'h200));
        branch(32'h200, 32'h200, 0, 1, 32'h180);
        apply(idle(32'h200));
        // Not-taken mispredicts including address wrap.
        branch(32'h100, 32'h200, 0, 1, 32'h180);
        branch(32'h100, 32'hFFFF_FFFC, 0, 1, 32'h180);
        // Re-train 0x200 to taken, then check redirect priorities.
        branch(32'h100, 32'h200, 1, 0, 32'h180);
        branch(32'h100, 32'h200, 1, 0, 32'h180);
        s = idle(32'h200); s.jalr = 1; s.jalr_t = 32'h5000; s.jal = 1; s.jal_t = 32'h6000;
        s.br = 1; s.pcx = 32'h300; s.tk = 1; s.pex = 0; s.br_t = 32'h7000;
        apply(s);
        s = idle(32'h200); s.jal = 1; s.jal_t = 32'h6000;
        apply(s);
        apply(idle(32'h200));
        // Alias replaces entry for 0x200.
        branch(32'h100, 32'h200 + 4 * ENTRIES, 1, 0, 32'h900);
        apply(idle(32'h200));
        apply(idle(32'h200 + 4 * ENTRIES));
        // Reset mid-stream while a branch is in EX.
        s = idle(32'h200 + 4 * ENTRIES); s.r = 1; s.br = 1; s.pcx = 32'h200; s.tk = 1; s.pex = 0; s.br_t = 32'h44;
        apply(s);
        apply(idle(32'h200 + 4 * ENTRIES));
        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            s = idle(pick_pc());
            s.r      = ($urandom_range(299) == 0);
            s.br     = ($urandom_range(99) < 60);
            s.pcx    = pick_pc();
            s.tk     = $urandom_range(1);
            s.pex    = $urandom_range(1);
            s.br_t   = {$urandom_range(32'hFFFF) , 2'b00};
            s.jal    = ($urandom_range(9) == 0);
            s.jal_t  = $urandom;
            s.jalr   = ($urandom_range(9) == 0);
            s.jalr_t = $urandom;
            apply(s);
        end
        apply(idle(32'h100));
        drive_done = 1;
    end

endmodule
